// File: rtl/instruction_encoder.sv
// instruction_encoder: packs op/field requests into RV32 words streamed with instruction-memory addresses; IMM_CHECK_EN enables immediate range faults
module instruction_encoder #(
  parameter int ADDR_W     = 10,
  parameter int PROG_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W:0]   acnt_q, acnt_d;
  logic              err_q, err_d;
  logic              accept, bad;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [31:0]       enc;
  assign full      = acnt_q == (ADDR_W+1)'(PROG_DEPTH);
  assign in_ready  = !full && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
`ifdef IMM_CHECK_EN
`else
  logic unused_imm;
  assign unused_imm = &{1'b0, in_imm[31:20]};
`endif
  // field selection and word assembly; illegal ops and range faults collapse to NOP
  always_comb begin
    f7 = (in_op == 5'd1 || in_op == 5'd12 || in_op == 5'd19) ? 7'h20 :
         (in_op >= 5'd2 && in_op <= 5'd4) ? 7'h01 : 7'h00;
    case (in_op)
      5'd3, 5'd10, 5'd17:         f3 = 3'd1;
      5'd5:                       f3 = 3'd2;
      5'd4, 5'd6:                 f3 = 3'd3;
      5'd9, 5'd16:                f3 = 3'd4;
      5'd11, 5'd12, 5'd18, 5'd19: f3 = 3'd5;
      5'd8, 5'd15:                f3 = 3'd6;
      5'd7, 5'd14:                f3 = 3'd7;
      default:                    f3 = 3'd0;
    endcase
    bad = in_op > 5'd21;
`ifdef IMM_CHECK_EN
    bad = bad ||
          (in_op >= 5'd13 && in_op <= 5'd16 && !(&in_imm[31:11] || ~|in_imm[31:11])) ||
          (in_op >= 5'd17 && in_op <= 5'd19 && |in_imm[31:5]) ||
          (in_op == 5'd20 && |in_imm[31:20]);
`endif
    enc = in_op <= 5'd12 ? {f7, in_rs2, in_rs1, f3, in_rd, 7'h33} :
          in_op <= 5'd16 ? {in_imm[11:0], in_rs1, f3, in_rd, 7'h13} :
          in_op <= 5'd19 ? {f7, in_imm[4:0], in_rs1, f3, in_rd, 7'h13} :
          in_op == 5'd20 ? {in_imm[19:0], in_rd, 7'h37} :
                           {in_imm[11:0], in_rs1, 3'd1, in_rd, 7'h73};
    enc = bad ? NOP : enc;
  end
  // output slot loads on accept, empties on drain; address is the count of prior accepts
  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_inst_d  = accept ? enc : out_inst_q;
    out_addr_d  = accept ? acnt_q[ADDR_W-1:0] : out_addr_q;
    acnt_d      = acnt_q + (ADDR_W+1)'(accept);
    err_d       = err_q || (accept && bad);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      acnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      acnt_q      <= acnt_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: randomized and directed checks of instruction_encoder against a behavioural model
module tb_instruction_encoder;
  localparam int DEPTH = 16;
  logic        clk = 0, rst, in_valid, in_ready, out_valid, out_ready, full, err;
  logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst;
  logic [9:0]  out_addr;
  int n_chk = 0, n_fail = 0;
  int f3tab[22] = '{0,0,0,1,3,2,3,7,6,4,1,5,5,0,7,6,4,1,5,5,0,1};
  bit          started = 0, m_valid;
  logic [31:0] m_inst;
  int          m_addr, m_cnt;
  bit          m_err;

  instruction_encoder #(.ADDR_W(10), .PROG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .full(full), .err(err));

  always #5 clk = ~clk;

  function automatic logic [31:0] model_enc(input int op, input logic [4:0] rd, rs1, rs2,
                                            input logic [31:0] imm, output bit bad);
    logic [31:0] r, f7, f3;
    bad = op > 21;
    f7 = (op == 1 || op == 12 || op == 19) ? 32 : (op >= 2 && op <= 4) ? 1 : 0;
    f3 = bad ? 0 : 32'(f3tab[op]);
    if (op <= 12)      r = f7 * 2**25 + 32'(rs2) * 2**20 + 32'(rs1) * 2**15 + f3 * 2**12 + 32'(rd) * 2**7 + 32'h33;
    else if (op <= 16) r = (imm % 4096) * 2**20 + 32'(rs1) * 2**15 + f3 * 2**12 + 32'(rd) * 2**7 + 32'h13;
    else if (op <= 19) r = f7 * 2**25 + (imm % 32) * 2**20 + 32'(rs1) * 2**15 + f3 * 2**12 + 32'(rd) * 2**7 + 32'h13;
    else if (op == 20) r = (imm % 2**20) * 2**12 + 32'(rd) * 2**7 + 32'h37;
    else               r = (imm % 4096) * 2**20 + 32'(rs1) * 2**15 + 32'h1000 + 32'(rd) * 2**7 + 32'h73;
`ifdef IMM_CHECK_EN
    if (op >= 13 && op <= 16 && ($signed(imm) < -2048 || $signed(imm) > 2047)) bad = 1;
    if (op >= 17 && op <= 19 && imm > 31) bad = 1;
    if (op == 20 && imm >= 32'h100000) bad = 1;
`endif
    return bad ? 32'h13 : r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: one output slot, accept counter, sticky error
  always @(posedge clk) begin
    bit b, rdy;
    logic [31:0] w;
    if (rst) begin
      m_valid = 0; m_inst = 0; m_addr = 0; m_cnt = 0; m_err = 0; started = 1;
    end else begin
      rdy = m_cnt != DEPTH && (!m_valid || out_ready);
      if (in_valid && rdy) begin
        w = model_enc(int'(in_op), in_rd, in_rs1, in_rs2, in_imm, b);
        m_inst = w; m_addr = m_cnt; m_cnt++; m_valid = 1;
        if (b) m_err = 1;
      end else if (out_ready) m_valid = 0;
    end
  end

  // per-cycle comparison away from the active edge
  always @(negedge clk) if (started) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_inst", out_inst, m_inst);
    chk("out_addr", 32'(out_addr), 32'(m_addr));
    chk("full", 32'(full), 32'(m_cnt == DEPTH));
    chk("err", 32'(err), 32'(m_err));
    chk("in_ready", 32'(in_ready), 32'(m_cnt != DEPTH && (!m_valid || out_ready)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    in_op = 5'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    set_req(op, rd, rs1, rs2, imm);
    in_valid = 1;
    step();
    in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0;
    step();
    rst = 0;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom % 4)
      0: return 32'($urandom_range(0, 31));
      1: return 32'($signed(12'($urandom)));
      2: return 32'($urandom % 2**20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit b;
    logic [31:0] v;
    rst = 1; in_valid = 0; out_ready = 1; set_req(0, 0, 0, 0, 0);
    v = model_enc(0, 1, 2, 3, 0, b);          chk("model ADD", v, 32'h003100B3);
    v = model_enc(2, 1, 2, 3, 0, b);          chk("model MUL", v, 32'h023100B3);
    v = model_enc(13, 5, 0, 0, -1, b);        chk("model ADDI", v, 32'hFFF00293);
    v = model_enc(19, 6, 7, 0, 3, b);         chk("model SRAI", v, 32'h4033D313);
    v = model_enc(20, 10, 0, 0, 32'h12345, b); chk("model LUI", v, 32'h12345537);
    v = model_enc(21, 0, 4, 0, 32'hF02, b);   chk("model CSRRW", v, 32'hF0221073);
    step(); step();
    rst = 0;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset err", 32'(err), 0);
    send(0, 1, 2, 3, 0);
    chk("ADD inst", out_inst, 32'h003100B3);
    chk("ADD addr", 32'(out_addr), 0);
    send(2, 1, 2, 3, 0);          chk("MUL inst", out_inst, 32'h023100B3);
    send(13, 5, 0, 0, -1);        chk("ADDI inst", out_inst, 32'hFFF00293);
    send(19, 6, 7, 0, 3);         chk("SRAI inst", out_inst, 32'h4033D313);
    send(20, 10, 0, 0, 32'h12345); chk("LUI inst", out_inst, 32'h12345537);
    send(21, 0, 4, 0, 32'hF02);   chk("CSRRW inst", out_inst, 32'hF0221073);
    chk("CSRRW addr", 32'(out_addr), 5);
    out_ready = 0;
    #1;
    set_req(1, 3, 3, 3, 0);
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall inst", out_inst, 32'hF0221073);
      chk("stall addr", 32'(out_addr), 5);
      chk("stall in_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("b2b addr", 32'(out_addr), 32'(6 + i));
      chk("b2b valid", 32'(out_valid), 1);
      set_req($urandom_range(0, 21), $urandom, $urandom, $urandom, rand_imm());
    end
    in_valid = 0;
    send(25, 1, 1, 1, 0);
    chk("illegal inst", out_inst, 32'h13);
    chk("illegal err", 32'(err), 1);
    chk("illegal addr", 32'(out_addr), 14);
    send(0, 1, 2, 3, 0);
    chk("full", 32'(full), 1);
    chk("full in_ready", 32'(in_ready), 0);
    chk("last addr", 32'(out_addr), 15);
    step();
    chk("last drained", 32'(out_valid), 0);
    chk("err sticky", 32'(err), 1);
    out_ready = 0;
    send(0, 1, 2, 3, 0);
    rst = 1;
    step();
    rst = 0;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_addr", 32'(out_addr), 0);
    chk("rst err", 32'(err), 0);
    chk("rst full", 32'(full), 0);
    out_ready = 1;
`ifdef IMM_CHECK_EN
    send(13, 1, 1, 0, 4096);
    chk("immchk inst", out_inst, 32'h13);
    chk("immchk err", 32'(err), 1);
    do_reset();
`endif
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom % 40) == 0;
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 10) < 7;
      set_req(($urandom % 8) == 0 ? $urandom_range(22, 31) : $urandom_range(0, 21),
              $urandom, $urandom, $urandom, rand_imm());
      step();
    end
    rst = 0;
    step();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
